// File: rtl/adc_pkg.sv
// Shared ADC definitions: the SAR state encoding and the default resolution.
package adc_pkg;

  localparam int ADC_BITS = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_t;

endpackage

// File: rtl/sar_controller.sv
// Successive-approximation ADC controller: it runs the track/hold, drives
// trial codes to an external capacitive DAC, reads back an external
// comparator, and publishes each finished result with a one-cycle strobe.
//
// Handshake: start and cont are levels that are looked at only in IDLE and
// DONE. They are never queued. valid is a one-cycle strobe with no
// backpressure. Dout is meaningful in the strobe cycle and holds its value
// until the next strobe.
//
// A request seen in IDLE is registered for one cycle before SAMPLE begins.
// As a result, valid rises T_SAMPLE+N+1 edges after the edge that sampled
// the request. From DONE, a request goes straight to SAMPLE, so continuous
// mode produces one result every T_SAMPLE+N+1 cycles.
// N must be at least 2.
module sar_controller
  import adc_pkg::*;
#(
  parameter int N        = ADC_BITS,
  parameter int T_SAMPLE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         cont,
  input  logic         cmp,
  output logic         sh,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic [N-1:0] Dout,
  output logic         valid,
  output sar_state_t   state_dbg
);

  localparam int CW = $clog2(T_SAMPLE + 1);
  localparam int BW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_SAMPLE - 1);
  localparam logic [BW-1:0] BIT_MSB  = BW'(N - 1);
  localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

  sar_state_t    state_q, state_d;
  logic          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  dout_q, dout_d;
  logic [N-1:0]  dac_q, dac_d;
  logic          sh_q, sh_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;

  // Next-state logic. The outputs are decoded from the next state, so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    res_d   = res_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (req_q) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          req_d = start | cont;
        end
      end
      SAMPLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CONVERT;
          bit_d   = BIT_MSB;
          res_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONVERT: begin
        // Keep the trial bit when the input is at or above the DAC level.
        if (cmp) res_d = dac_q;
        if (bit_q == '0) begin
          state_d = DONE;
          dout_d  = res_d;
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      DONE: begin
        if (start | cont) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    sh_d    = (state_d == SAMPLE);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
    dac_d   = (state_d == CONVERT) ? (res_d | (ONE << bit_d)) : '0;
  end

  // State and output registers; reset clears everything and drops any
  // conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      dac_q   <= '0;
      sh_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      dac_q   <= dac_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign sh        = sh_q;
  assign dac_code  = dac_q;
  assign busy      = busy_q;
  assign Dout      = dout_q;
  assign valid     = valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sar_controller.sv
// Bench for sar_controller: table-driven single conversions, randomized
// codes, continuous mode, mid-conversion reset and ignored start pulses.
module tb_sar_controller;
  import adc_pkg::*;

  localparam int N   = 12;
  localparam int T   = 4;
  localparam int LAT = T + N + 1;

  logic         clk = 1'b0;
  logic         reset, start, cont, cmp;
  logic         sh, busy, valid;
  logic [N-1:0] dac_code, Dout;
  sar_state_t   state_dbg;

  int checks   = 0;
  int failures = 0;

  // Comparator model: 0 = analog input equals target, 1 = tied high, 2 = tied low
  logic [1:0]   cmp_mode;
  logic [N-1:0] target;

  typedef struct {
    logic [1:0]   mode;
    logic [N-1:0] tgt;
    logic [N-1:0] exp_dout;
    logic         mid_start;
  } vec_t;

  vec_t vecs[6];

  sar_controller #(.N(N), .T_SAMPLE(T)) dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .cmp(cmp),
    .sh(sh), .dac_code(dac_code), .busy(busy), .Dout(Dout), .valid(valid),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  always_comb begin
    case (cmp_mode)
      2'd1:    cmp = 1'b1;
      2'd2:    cmp = 1'b0;
      default: cmp = (target >= dac_code);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Trial code at bit i of a binary search that ends at result r:
  // the decided upper bits of r with bit i set and all lower bits clear.
  function automatic logic [N-1:0] trial(input logic [N-1:0] r, input int i);
    logic [N-1:0] hi;
    logic [N-1:0] one;
    one = 1;
    hi  = (r >> (i + 1)) << (i + 1);
    return hi | (one << i);
  endfunction

  // One conversion from IDLE, with optional start pulses in SAMPLE and CONVERT.
  task automatic run_conv(input string name, input logic [1:0] mode, input logic [N-1:0] tgt,
                          input logic [N-1:0] exp, input logic mid);
    logic [N-1:0] exp_q[$];
    logic [N-1:0] e;
    logic [N-1:0] dv;
    int nvalid, vk, nsh;
    logic hold_ok;
    nvalid = 0; vk = -1; nsh = 0; hold_ok = 1'b1; dv = '0;
    for (int i = N - 1; i >= 0; i--) exp_q.push_back(trial(exp, i));
    @(negedge clk);
    cmp_mode = mode;
    target   = tgt;
    start    = 1'b1;
    for (int k = 0; k < LAT + 8; k++) begin
      @(negedge clk);
      start = mid && (k == 2 || k == 9);
      if (sh) nsh++;
      if (dac_code != '0) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({name, "_dac"}, dac_code, e);
        end else begin
          chk({name, "_dac_extra"}, dac_code, 0);
        end
      end
      if (vk >= 0 && Dout !== dv) hold_ok = 1'b0;
      if (valid) begin
        nvalid++;
        if (vk < 0) begin
          vk = k;
          dv = Dout;
        end
      end
    end
    chk({name, "_latency"}, vk, LAT);
    chk({name, "_nvalid"}, nvalid, 1);
    chk({name, "_dout"}, dv, exp);
    chk({name, "_sh_cycles"}, nsh, T);
    chk({name, "_dac_count"}, exp_q.size(), 0);
    chk({name, "_dout_hold"}, hold_ok, 1);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_state_end"}, 32'(state_dbg), 32'(IDLE));
  endtask

  task automatic run_cont();
    logic [N-1:0] codes[5];
    int vks[5];
    int nv;
    codes = '{12'h001, 12'h7FF, 12'h800, 12'hFFE, 12'h123};
    nv = 0;
    @(negedge clk);
    cmp_mode = 2'd0;
    target   = codes[0];
    cont     = 1'b1;
    for (int k = 0; k < 5 * LAT + 10; k++) begin
      @(negedge clk);
      if (valid) begin
        if (nv < 5) begin
          chk("cont_dout", Dout, codes[nv]);
          vks[nv] = k;
          if (nv == 0) chk("cont_first_lat", k, LAT);
          else         chk("cont_period", k - vks[nv-1], LAT);
        end
        nv++;
        if (nv < 5) target = codes[nv];
        else        cont = 1'b0;
      end
    end
    cont = 1'b0;
    chk("cont_nvalid", nv, 5);
    chk("cont_busy_end", busy, 0);
    chk("cont_state_end", 32'(state_dbg), 32'(IDLE));
  endtask

  task automatic run_reset_mid();
    int nvalid;
    nvalid = 0;
    @(negedge clk);
    cmp_mode = 2'd0;
    target   = 12'h5A3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // k=0 now; CONVERT spans k=5..16, so its 6th cycle is k=10
    repeat (10) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    chk("rst_mid_in_convert", 32'(state_dbg), 32'(CONVERT));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_mid_sh", sh, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_dac", dac_code, 0);
    chk("rst_mid_dout", Dout, 0);
    reset = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    chk("rst_mid_no_valid", nvalid, 0);
    chk("rst_mid_idle", 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    vecs[0] = '{mode: 2'd0, tgt: 12'hA5C, exp_dout: 12'hA5C, mid_start: 1'b0};
    vecs[1] = '{mode: 2'd1, tgt: 12'h000, exp_dout: 12'hFFF, mid_start: 1'b0};
    vecs[2] = '{mode: 2'd2, tgt: 12'hFFF, exp_dout: 12'h000, mid_start: 1'b0};
    vecs[3] = '{mode: 2'd0, tgt: 12'h001, exp_dout: 12'h001, mid_start: 1'b0};
    vecs[4] = '{mode: 2'd0, tgt: 12'hFFF, exp_dout: 12'hFFF, mid_start: 1'b0};
    vecs[5] = '{mode: 2'd0, tgt: 12'h3C7, exp_dout: 12'h3C7, mid_start: 1'b1};

    reset = 1'b1; start = 1'b0; cont = 1'b0; cmp_mode = 2'd0; target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));
    chk("reset_sh", sh, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_dac", dac_code, 0);
    chk("reset_dout", Dout, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_without_request", busy, 0);

    for (int v = 0; v < 6; v++)
      run_conv($sformatf("vec%0d", v), vecs[v].mode, vecs[v].tgt, vecs[v].exp_dout, vecs[v].mid_start);

    for (int r = 0; r < 6; r++) begin
      logic [N-1:0] t;
      t = N'($urandom_range(0, (1 << N) - 1));
      // A binary search against "input >= trial" lands on the input code itself.
      run_conv($sformatf("rnd%0d", r), 2'd0, t, t, 1'($urandom_range(0, 1)));
    end

    run_cont();
    run_reset_mid();
    run_conv("after_reset", 2'd0, 12'h6B1, 12'h6B1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar_controller.md
SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
REQ-001 Parameter N, default 12: conversion resolution in bits, equal to the averager's input width.
REQ-002 Parameter T_SAMPLE, default 4, minimum 1: track/hold acquisition length in clock cycles.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: conversion request, sampled only in IDLE and DONE.
REQ-006 Port cont, input, 1 bit: continuous mode; 1 = start a new conversion immediately after each DONE.
REQ-007 Port cmp, input, 1 bit: comparator result; 1 = Vin >= Vdac(dac_code).
REQ-008 Port sh, output, 1 bit: track/hold control; 1 = track.
REQ-009 Port dac_code, output, N bits: trial code driven to the capacitive DAC.
REQ-010 Port busy, output, 1 bit: 1 in SAMPLE, CONVERT and DONE.
REQ-011 Port Dout, output, N bits: last completed conversion result.
REQ-012 Port valid, output, 1 bit: one-cycle strobe marking a new Dout; wired directly to the averager EN.

Function
REQ-013 The FSM SHALL have states IDLE, SAMPLE, CONVERT and DONE; all outputs SHALL be registered.
REQ-014 IDLE: if start=1 or cont=1, go to SAMPLE with the sample counter at 0; otherwise stay in IDLE.
REQ-015 SAMPLE: sh=1 for exactly T_SAMPLE cycles, then go to CONVERT with the trial bit at N-1 and the result register at 0.
REQ-016 CONVERT: each cycle, dac_code = result OR (1 << bit).
  - At the edge, if cmp=1 the bit is kept, otherwise it is cleared.
  - The trial then moves to bit-1.
  - The state SHALL last exactly N cycles (MSB first).
REQ-017 After bit 0 is decided, go to DONE.
  - At that same edge, Dout loads the final result.
  - valid=1 for exactly one cycle (the DONE cycle).
REQ-018 DONE: go to SAMPLE if start=1 or cont=1, otherwise go to IDLE.
REQ-019 Latency: valid SHALL be high in the cycle beginning T_SAMPLE+N+1 edges after the edge that samples start in IDLE (17 for the defaults).
REQ-020 Throughput in continuous mode SHALL be one result every T_SAMPLE+N+1 cycles, with no idle gap.
REQ-021 start asserted during SAMPLE or CONVERT SHALL be ignored; it is not queued.
REQ-022 Dout SHALL hold its value between valid strobes.
REQ-023 Outside CONVERT, dac_code SHALL be 0 and sh SHALL be 0 (hold), except during SAMPLE.
REQ-024 The sample counter SHALL be ceil(log2(T_SAMPLE+1)) bits and the bit index ceil(log2(N)) bits; neither SHALL wrap within a state.

Reset
REQ-025 When reset=1 at an edge, the FSM SHALL go to IDLE and sh, busy, valid, dac_code, Dout and all counters SHALL be 0, regardless of state.
REQ-026 Reset mid-conversion SHALL abort the conversion with no valid strobe; Dout SHALL read 0.
REQ-027 The first conversion after reset release SHALL start only on start=1 or cont=1 seen in IDLE.

Structure
REQ-028 A shared package adc_pkg SHALL hold the state enum sar_state_t and the default resolution constant ADC_BITS = 12; the averager and this block SHALL use it.
REQ-029 The block SHALL be a single module with no sub-module.
REQ-030 The comparator and DAC SHALL stay outside the block.

Verification
REQ-031 Bench comparator model cmp = (0xA5C >= dac_code), single start pulse -> Dout=0xA5C, valid for 1 cycle, 17 cycles after the start edge.
REQ-032 cmp tied to 1 -> Dout=0xFFF; cmp tied to 0 -> Dout=0x000; dac_code sequence in the first case is 0x800, 0xC00, 0xE00, ..., 0xFFF.
REQ-033 cont=1 held for 5 conversions with input codes 0x001, 0x7FF, 0x800, 0xFFE, 0x123 -> five valid strobes exactly 17 cycles apart carrying those codes in order.
REQ-034 reset asserted in the 6th CONVERT cycle -> next cycle state=IDLE, all outputs 0, no valid strobe; a subsequent start converts correctly.
REQ-035 start pulsed during SAMPLE and CONVERT with cont=0 -> exactly one valid, then return to IDLE with busy=0.
REQ-036 Averager (power=2) fed from valid/Dout with constant input 0x400 -> averager output 0x400 after 4 strobes.
